// File: rtl/cpu_pkg.sv
// Shared encodings for the instruction controller and datapath: opcodes, sub-ops,
// mem_cmd/ALUop/vsel codes and the controller state enum (S_HALT only with CTRL_HALT_EN).
package cpu_pkg;
  localparam logic [2:0] OP_LDR  = 3'b011;
  localparam logic [2:0] OP_STR  = 3'b100;
  localparam logic [2:0] OP_ALU  = 3'b101;
  localparam logic [2:0] OP_MOV  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] SUB_ADD    = 2'b00;
  localparam logic [1:0] SUB_CMP    = 2'b01;
  localparam logic [1:0] SUB_AND    = 2'b10;
  localparam logic [1:0] SUB_MVN    = 2'b11;
  localparam logic [1:0] SUB_MOVREG = 2'b00;
  localparam logic [1:0] SUB_MOVIMM = 2'b10;

  localparam logic [1:0] MCMD_NONE  = 2'b00;
  localparam logic [1:0] MCMD_READ  = 2'b01;
  localparam logic [1:0] MCMD_WRITE = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM,
    S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG,
    S_MEM_ADDR, S_LOAD_ADDR, S_MEM_RD, S_MEM_WB,
    S_GET_RD, S_STR_DATA, S_MEM_WR
`ifdef CTRL_HALT_EN
    , S_HALT
`endif
  } state_e;
endpackage

// File: rtl/instr_controller_if.sv
// Controller <-> datapath bundle: ir flows to the controller, controls flow back.
interface instr_controller_if;
  logic [15:0] ir;
  logic [2:0]  writenum, readnum;
  logic [1:0]  shift, ALUop, vsel, mem_cmd;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic        load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;

  modport master (
    input  ir,
    output writenum, readnum, shift, ALUop, vsel, mem_cmd,
           write, loada, loadb, loadc, loads, asel, bsel,
           load_ir, load_pc, reset_pc, load_addr, addr_sel, halted
  );
  modport slave (
    output ir,
    input  writenum, readnum, shift, ALUop, vsel, mem_cmd,
           write, loada, loadb, loadc, loads, asel, bsel,
           load_ir, load_pc, reset_pc, load_addr, addr_sel, halted
  );
endinterface

// File: rtl/instr_field_decode.sv
// Pure field split of the 16-bit instruction plus instruction-class flags.
module instr_field_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output logic [2:0]  op_o,
  output logic [1:0]  sub_o,
  output logic [2:0]  rn_o,
  output logic [2:0]  rd_o,
  output logic [2:0]  rm_o,
  output logic [1:0]  sh_o,
  output logic        is_alu_o,
  output logic        is_mem_o,
  output logic        is_halt_o
);
  assign op_o  = ir_i[15:13];
  assign sub_o = ir_i[12:11];
  assign rn_o  = ir_i[10:8];
  assign rd_o  = ir_i[7:5];
  assign sh_o  = ir_i[4:3];
  assign rm_o  = ir_i[2:0];

  // MOV imm is not counted as ALU: it writes straight from the immediate path.
  assign is_alu_o  = (op_o == OP_ALU) || (op_o == OP_MOV && sub_o == SUB_MOVREG);
  assign is_mem_o  = (op_o == OP_LDR) || (op_o == OP_STR);
  assign is_halt_o = (op_o == OP_HALT);
endmodule

// File: rtl/instr_controller.sv
// Moore FSM sequencing fetch, decode and execute of the 16-bit ISA.
// Optional CTRL_HALT_EN: op=111 parks in S_HALT until reset; otherwise it is a NOP.
module instr_controller
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  instr_controller_if.master bus
);
  state_e     state_q, state_d;
  logic [2:0] op, rn, rd, rm;
  logic [1:0] sub, sh;
  logic       is_alu, is_mem, is_halt;

`ifdef CTRL_HALT_EN
  localparam state_e HALT_NEXT = S_HALT;
`else
  localparam state_e HALT_NEXT = S_IF1;
`endif

  instr_field_decode u_dec (
    .ir_i(bus.ir), .op_o(op), .sub_o(sub), .rn_o(rn), .rd_o(rd), .rm_o(rm),
    .sh_o(sh), .is_alu_o(is_alu), .is_mem_o(is_mem), .is_halt_o(is_halt)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;

  always_comb begin
    state_d       = S_IF1;
    bus.writenum  = '0;
    bus.readnum   = '0;
    bus.shift     = '0;
    bus.ALUop     = ALU_ADD;
    bus.vsel      = VSEL_MDATA;
    bus.mem_cmd   = MCMD_NONE;
    bus.write     = 1'b0;
    bus.loada     = 1'b0;
    bus.loadb     = 1'b0;
    bus.loadc     = 1'b0;
    bus.loads     = 1'b0;
    bus.asel      = 1'b0;
    bus.bsel      = 1'b0;
    bus.load_ir   = 1'b0;
    bus.load_pc   = 1'b0;
    bus.reset_pc  = 1'b0;
    bus.load_addr = 1'b0;
    bus.addr_sel  = 1'b0;
    bus.halted    = 1'b0;
    case (state_q)
      S_RST: begin
        bus.reset_pc = 1'b1;
        bus.load_pc  = 1'b1;
        state_d      = S_IF1;
      end
      S_IF1: begin
        bus.addr_sel = 1'b1;
        bus.mem_cmd  = MCMD_READ;
        state_d      = S_IF2;
      end
      S_IF2: begin
        bus.addr_sel = 1'b1;
        bus.mem_cmd  = MCMD_READ;
        bus.load_ir  = 1'b1;
        state_d      = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        bus.load_pc = 1'b1;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Anything not matched below is an undefined encoding and falls back to IF1.
        if (is_halt)                                   state_d = HALT_NEXT;
        else if (op == OP_MOV && sub == SUB_MOVIMM)    state_d = S_WRITE_IMM;
        else if (is_mem)                               state_d = S_GET_A;
        else if (is_alu)
          state_d = (op == OP_MOV || sub == SUB_MVN) ? S_GET_B : S_GET_A;
      end
      S_WRITE_IMM: begin
        bus.writenum = rn;
        bus.vsel     = VSEL_IMM;
        bus.write    = 1'b1;
      end
      S_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        state_d     = is_mem ? S_MEM_ADDR : S_GET_B;
      end
      S_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        bus.shift = sh;
        bus.ALUop = (op == OP_MOV) ? ALU_ADD : sub;
        bus.asel  = (op == OP_MOV) || (sub == SUB_MVN);
        if (op == OP_ALU && sub == SUB_CMP) begin
          bus.loads = 1'b1;
        end else begin
          bus.loadc = 1'b1;
          state_d   = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        bus.writenum = rd;
        bus.vsel     = VSEL_C;
        bus.write    = 1'b1;
      end
      S_MEM_ADDR: begin
        bus.bsel  = 1'b1;
        bus.loadc = 1'b1;
        state_d   = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        bus.load_addr = 1'b1;
        state_d       = (op == OP_LDR) ? S_MEM_RD : S_GET_RD;
      end
      S_MEM_RD: begin
        bus.mem_cmd = MCMD_READ;
        state_d     = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.mem_cmd  = MCMD_READ;
        bus.vsel     = VSEL_MDATA;
        bus.writenum = rd;
        bus.write    = 1'b1;
      end
      S_GET_RD: begin
        bus.readnum = rd;
        bus.loadb   = 1'b1;
        state_d     = S_STR_DATA;
      end
      S_STR_DATA: begin
        bus.asel  = 1'b1;
        bus.loadc = 1'b1;
        state_d   = S_MEM_WR;
      end
      S_MEM_WR: bus.mem_cmd = MCMD_WRITE;
`ifdef CTRL_HALT_EN
      S_HALT: begin
        bus.halted = 1'b1;
        state_d    = S_HALT;
      end
`endif
      default: state_d = S_IF1;
    endcase
  end
endmodule

// File: tb/tb_instr_controller.sv
// Bench for instr_controller: per-instruction expected output sequences derived from the ISA rules.
module tb_instr_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instr_controller_if bus();
  instr_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [2:0] writenum, readnum;
    logic [1:0] shift, ALUop, vsel, mem_cmd;
    logic write, loada, loadb, loadc, loads, asel, bsel;
    logic load_ir, load_pc, reset_pc, load_addr, addr_sel, halted;
  } ctl_t;

  int   errs = 0;
  int   checks = 0;
  ctl_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctl_t sample();
    ctl_t c;
    c.writenum = bus.writenum; c.readnum = bus.readnum; c.shift = bus.shift;
    c.ALUop = bus.ALUop; c.vsel = bus.vsel; c.mem_cmd = bus.mem_cmd;
    c.write = bus.write; c.loada = bus.loada; c.loadb = bus.loadb; c.loadc = bus.loadc;
    c.loads = bus.loads; c.asel = bus.asel; c.bsel = bus.bsel; c.load_ir = bus.load_ir;
    c.load_pc = bus.load_pc; c.reset_pc = bus.reset_pc; c.load_addr = bus.load_addr;
    c.addr_sel = bus.addr_sel; c.halted = bus.halted;
    return c;
  endfunction

  // Expected per-cycle controls from IF1 up to (not including) the next IF1.
  task automatic build(input logic [15:0] ir);
    logic [2:0] op, rn, rd, rm;
    logic [1:0] sub, sh;
    logic mov, unary, cmp;
    ctl_t c;
    op = ir[15:13]; sub = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    exp_q.delete();
    c = '0; c.addr_sel = 1; c.mem_cmd = 2'b01; exp_q.push_back(c);
    c.load_ir = 1; exp_q.push_back(c);
    c = '0; c.load_pc = 1; exp_q.push_back(c);
    c = '0; exp_q.push_back(c);
    if (op == 3'b110 && sub == 2'b10) begin
      c = '0; c.writenum = rn; c.vsel = 2'b01; c.write = 1; exp_q.push_back(c);
    end else if (op == 3'b101 || (op == 3'b110 && sub == 2'b00)) begin
      mov = (op == 3'b110); unary = mov || sub == 2'b11; cmp = !mov && sub == 2'b01;
      if (!unary) begin c = '0; c.readnum = rn; c.loada = 1; exp_q.push_back(c); end
      c = '0; c.readnum = rm; c.loadb = 1; exp_q.push_back(c);
      c = '0; c.shift = sh; c.ALUop = mov ? 2'b00 : sub; c.asel = unary;
      if (cmp) c.loads = 1; else c.loadc = 1;
      exp_q.push_back(c);
      if (!cmp) begin c = '0; c.writenum = rd; c.vsel = 2'b11; c.write = 1; exp_q.push_back(c); end
    end else if (op == 3'b011 || op == 3'b100) begin
      c = '0; c.readnum = rn; c.loada = 1; exp_q.push_back(c);
      c = '0; c.bsel = 1; c.loadc = 1; exp_q.push_back(c);
      c = '0; c.load_addr = 1; exp_q.push_back(c);
      if (op == 3'b011) begin
        c = '0; c.mem_cmd = 2'b01; exp_q.push_back(c);
        c.writenum = rd; c.write = 1; exp_q.push_back(c);
      end else begin
        c = '0; c.readnum = rd; c.loadb = 1; exp_q.push_back(c);
        c = '0; c.asel = 1; c.loadc = 1; exp_q.push_back(c);
        c = '0; c.mem_cmd = 2'b10; exp_q.push_back(c);
      end
    end
`ifdef CTRL_HALT_EN
    else if (op == 3'b111) begin
      c = '0; c.halted = 1;
      repeat (20) exp_q.push_back(c);
    end
`endif
  endtask

  // Garbage ir during IF1/IF2/UPDATE_PC; the real instruction from DECODE on.
  task automatic run_instr(input logic [15:0] ir, input string tag, input int ncyc);
    ctl_t o;
    build(ir);
    for (int i = 0; i < exp_q.size() && i < ncyc; i++) begin
      @(posedge clk); #1;
      bus.ir = (i < 3) ? 16'($urandom) : ir;
      #1;
      o = sample();
      chk($sformatf("%s.c%0d", tag, i), 32'(o), 32'(exp_q[i]));
      chk($sformatf("%s.wr_vs_memwr%0d", tag, i), 32'(o.write && o.mem_cmd == 2'b10), 32'd0);
      chk($sformatf("%s.ir_vs_pc%0d", tag, i), 32'(o.load_ir && o.load_pc), 32'd0);
    end
  endtask

  task automatic do_reset(input string tag);
    ctl_t r;
    r = '0; r.reset_pc = 1; r.load_pc = 1;
    rst_n = 1'b0; #1;
    chk({tag, ".now"}, 32'(sample()), 32'(r));
    @(posedge clk); #2;
    chk({tag, ".hold"}, 32'(sample()), 32'(r));
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] ir;
    bus.ir = 16'h0000;
    do_reset("rst0");
    run_instr(16'hD007, "movimm", 1000);
    run_instr(16'hA148, "add", 1000);
    run_instr(16'hA900, "cmp", 1000);
    run_instr(16'h6164, "ldr", 1000);
    run_instr(16'h8164, "str", 1000);
    run_instr(16'hC00A, "movreg", 1000);
    run_instr(16'hB813, "mvn", 1000);
    run_instr(16'hB2A5, "and", 1000);
    run_instr(16'hD000, "movimm_r0", 1000);
    run_instr(16'h2345, "nop", 1000);
    // IF1..EXEC of ADD, then reset lands mid-EXEC
    run_instr(16'hA148, "add_cut", 7);
    do_reset("rst_exec");
    for (int k = 0; k < 40; k++) begin
      ir = 16'($urandom);
      if (ir[15:13] == 3'b111) ir[15:13] = 3'($urandom_range(0, 6));
      run_instr(ir, $sformatf("rnd%0d_%h", k, ir), 1000);
    end
    run_instr(16'hE000, "op111", 1000);
    do_reset("rst_end");
    run_instr(16'hA148, "add_after", 1000);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/instr_controller.md
INSTR_CONTROLLER -- requirements
Module: instr_controller

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: ir  in  16  instruction register contents, with fields op[15:13], sub[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0].
REQ-004 SHALL have datapath controls: writenum, readnum  out  3; shift, ALUop  out  2; vsel  out  2; write, loada, loadb, loadc, loads, asel, bsel  out  1.
REQ-005 SHALL have fetch/memory controls: load_ir, load_pc, reset_pc, load_addr, addr_sel  out  1; mem_cmd  out  2 (00 none, 01 read, 10 write); halted  out  1.

Function
REQ-006 SHALL be a Moore FSM; outputs decode from the state register plus ir fields only, and every output not listed for a state SHALL be 0.
REQ-007 SHALL sequence RST(reset_pc, load_pc) -> IF1(addr_sel, mem_cmd=01) -> IF2(addr_sel, mem_cmd=01, load_ir) -> UPDATE_PC(load_pc) -> DECODE, one cycle each.
REQ-008 For MOV imm (op=110, sub=10), SHALL go DECODE -> WRITE_IMM(writenum=Rn, vsel=01, write) -> IF1, for 5 cycles per instruction.
REQ-009 For ADD/CMP/AND (op=101, sub=00/01/10), SHALL go GET_A(readnum=Rn, loada) -> GET_B(readnum=Rm, loadb) -> EXEC(shift=sh, ALUop=sub).
REQ-010 In EXEC, CMP SHALL assert loads only and return to IF1; ADD and AND SHALL assert loadc and then go to WRITE_REG(writenum=Rd, vsel=11, write) -> IF1.
REQ-011 MOV reg (op=110, sub=00) and MVN (op=101, sub=11) SHALL skip GET_A, and EXEC SHALL assert asel=1.
REQ-012 MOV reg SHALL use ALUop=00; MVN SHALL use ALUop=11.
REQ-013 For LDR (op=011), SHALL go GET_A -> MEM_ADDR(asel=0, bsel=1, ALUop=00, loadc) -> LOAD_ADDR(load_addr) -> MEM_RD(mem_cmd=01) -> MEM_WB(mem_cmd=01, vsel=00, writenum=Rd, write) -> IF1.
REQ-014 For STR (op=100), SHALL go GET_A -> MEM_ADDR -> LOAD_ADDR -> GET_RD(readnum=Rd, loadb) -> STR_DATA(asel=1, shift=00, ALUop=00, loadc) -> MEM_WR(mem_cmd=10) -> IF1.
REQ-015 SHALL treat any undefined op/sub combination as a NOP: DECODE -> IF1 with no write, loads or mem_cmd.
REQ-016 SHALL sample ir only in DECODE and later states; ir changes during IF1/IF2 SHALL NOT affect outputs.
REQ-017 SHALL never assert write and mem_cmd=10 in the same cycle.
REQ-018 SHALL never assert load_ir and load_pc in the same cycle.

Reset
REQ-019 rst_n low SHALL force state RST immediately, from any state including mid-instruction, with write=0, loads=0, mem_cmd=00 and halted=0.
REQ-020 While rst_n is low, reset_pc and load_pc SHALL both be 1.
REQ-021 The first rising clk edge after rst_n rises SHALL enter IF1.

Configuration
REQ-022 With CTRL_HALT_EN defined, op=111 SHALL go DECODE -> HALT, hold halted=1 with all other outputs 0, and leave only on reset.
REQ-023 Without CTRL_HALT_EN, op=111 SHALL be a NOP per REQ-015, halted SHALL be tied to 0, and no HALT state SHALL exist.

Structure
REQ-024 Package cpu_pkg SHALL hold the state enum, opcode/sub constants, mem_cmd encodings and ALUop/vsel encodings, all shared with the datapath top.
REQ-025 Sub-module instr_field_decode (combinational: ir -> op, sub, Rn, Rd, Rm, sh, is_alu, is_mem, is_halt) SHALL be instantiated once.

Verification
REQ-026 rst_n pulsed low during EXEC of ADD -> same cycle: state RST, write=0, reset_pc=1; after release -> IF1 on the next edge.
REQ-027 ir=16'hD007 (MOV R0,#7) -> WRITE_IMM shows writenum=0, vsel=01, write=1; the next IF1 comes 5 cycles after the prior IF1.
REQ-028 ir=16'hA148 (ADD R2,R1,R0,LSL#1) -> GET_A readnum=1, loada; GET_B readnum=0, loadb; EXEC shift=01, ALUop=00, loadc; WRITE_REG writenum=2, vsel=11.
REQ-029 ir=16'hA900 (CMP R1,R0) -> EXEC loads=1, write never asserted, then IF1.
REQ-030 ir=16'h6164 (LDR R3,[R1,#4]) -> MEM_ADDR bsel=1, loadc; MEM_RD mem_cmd=01, addr_sel=0; MEM_WB vsel=00, writenum=3, write=1.
REQ-031 ir=16'hE000 -> with CTRL_HALT_EN: halted=1 held for 20 cycles; without it: IF1 follows DECODE.
